// File: rtl/instancia_nbc.sv
// Three independent free-running up-counters (4/5/8 bits by default) sharing one clock and reset.
// Define INSTANCIA_NBC_SAT_EN to make each counter saturate at its maximum instead of wrapping.

module instancia_nbc_cnt #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset,
   output logic [N-1:0] count
);

   localparam logic [N-1:0] CNT_MAX = '1;

   // Reset wins over increment, wrap and saturation on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else begin
`ifdef INSTANCIA_NBC_SAT_EN
         if (count != CNT_MAX) begin
            count <= count + N'(1);
         end
`else
         count <= count + N'(1);
`endif
      end
   end

endmodule

module instancia_nbc #(
   parameter int unsigned WIDTH_A = 4,
   parameter int unsigned WIDTH_B = 5,
   parameter int unsigned WIDTH_C = 8
) (
   input  logic               clk,
   input  logic               reset,
   output logic [WIDTH_A-1:0] count4,
   output logic [WIDTH_B-1:0] count5,
   output logic [WIDTH_C-1:0] count8
);

   instancia_nbc_cnt #(.N(WIDTH_A)) u_cnt_a (
      .clk   (clk),
      .reset (reset),
      .count (count4)
   );

   instancia_nbc_cnt #(.N(WIDTH_B)) u_cnt_b (
      .clk   (clk),
      .reset (reset),
      .count (count5)
   );

   instancia_nbc_cnt #(.N(WIDTH_C)) u_cnt_c (
      .clk   (clk),
      .reset (reset),
      .count (count8)
   );

endmodule

// File: tb/tb_instancia_nbc.sv
// Directed bench for instancia_nbc; expected values follow INSTANCIA_NBC_SAT_EN when defined.

module tb_instancia_nbc;

   logic       clk;
   logic       reset;
   logic [3:0] count4;
   logic [4:0] count5;
   logic [7:0] count8;

   int unsigned checks;
   int unsigned errors;
   int unsigned k;

   typedef struct {
      int unsigned k;
      int unsigned e4;
      int unsigned e5;
      int unsigned e8;
   } vec_t;

`ifdef INSTANCIA_NBC_SAT_EN
   vec_t vecs[9] = '{
      '{1,   1,  1,  1},
      '{15, 15, 15, 15},
      '{16, 15, 16, 16},
      '{25, 15, 25, 25},
      '{31, 15, 31, 31},
      '{32, 15, 31, 32},
      '{40, 15, 31, 40},
      '{255, 15, 31, 255},
      '{256, 15, 31, 255}
   };
   localparam int unsigned E40_4 = 15;
   localparam int unsigned E40_5 = 31;
`else
   vec_t vecs[9] = '{
      '{1,   1,  1,  1},
      '{15, 15, 15, 15},
      '{16,  0, 16, 16},
      '{25,  9, 25, 25},
      '{31, 15, 31, 31},
      '{32,  0,  0, 32},
      '{255, 15, 31, 255},
      '{256,  0,  0,  0},
      '{257,  1,  1,  1}
   };
   localparam int unsigned E40_4 = 8;
   localparam int unsigned E40_5 = 8;
`endif

   instancia_nbc dut (
      .clk    (clk),
      .reset  (reset),
      .count4 (count4),
      .count5 (count5),
      .count8 (count8)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check3(input string tag, input int unsigned e4, input int unsigned e5,
                         input int unsigned e8);
      check({tag, ".count4"}, 32'(count4), e4);
      check({tag, ".count5"}, 32'(count5), e5);
      check({tag, ".count8"}, 32'(count8), e8);
   endtask

   // One rising edge, then settle away from the edge before sampling
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic advance_to(input int unsigned target);
      while (k < target) begin
         edge1();
         k++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      k      = 0;
      reset  = 1'b1;
      edge1();
      check3("reset", 0, 0, 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         advance_to(vecs[i].k);
         check3($sformatf("k%0d", vecs[i].k), vecs[i].e4, vecs[i].e5, vecs[i].e8);
      end

      // Reset exactly when count4 sits on its wrap value, then hold for three edges
      reset = 1'b1;
      edge1();
      reset = 1'b0;
      k = 0;
      advance_to(15);
      check3("pre_rst15", 15, 15, 15);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge1();
         check3($sformatf("rst_hold%0d", i), 0, 0, 0);
      end
      reset = 1'b0;
      k = 0;
      advance_to(1);
      check3("resume", 1, 1, 1);

      advance_to(40);
      check3("k40", E40_4, E40_5, 40);
      reset = 1'b1;
      edge1();
      check3("rst_pulse", 0, 0, 0);
      reset = 1'b0;
      edge1();
      check3("after_pulse", 1, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
